// File: rtl/glitch_seq_if.sv
// glitch_seq_if: command FIFO, control handshake and glitch-core outputs.
interface glitch_seq_if #(
  parameter int CMD_W  = 36,
  parameter int MODE_W = 8
);
  logic              start;
  logic              abort;
  logic [CMD_W-1:0]  fifo_in;
  logic              fifo_empty;
  logic              fifo_re;
  logic              ready;
  logic              rst_req;
  logic              glitch_en;
  logic [MODE_W-1:0] glitch_mode;
  logic              done;

  modport master (
    output start, abort, fifo_in, fifo_empty,
    input  fifo_re, ready, rst_req,
    input  glitch_en, glitch_mode, done
  );

  modport slave (
    input  start, abort, fifo_in, fifo_empty,
    output fifo_re, ready, rst_req,
    output glitch_en, glitch_mode, done
  );
endinterface

// File: rtl/glitch_seq.sv
// glitch_seq: drains a FIFO of {delay,width,repeat,mode} glitch commands.
// Define GLITCH_SEQ_TRIG_EN to hold each command's first pulse for trig_in.
module glitch_seq #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8,
  parameter int REP_W   = 4,
  parameter int MODE_W  = 8,
  localparam int CMD_W  = DELAY_W + WIDTH_W + REP_W + MODE_W
) (
  input  logic clk_in,
  input  logic rst,
`ifdef GLITCH_SEQ_TRIG_EN
  input  logic trig_in,
`endif
  glitch_seq_if.slave bus
);

`ifdef GLITCH_SEQ_TRIG_EN
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, DELAY, WIDTH, ARM
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, DELAY, WIDTH
  } state_e;
`endif

  state_e state_q, state_d;

  logic fifo_re_q, fifo_re_d;
  logic rst_req_q, rst_req_d;
  logic en_q, en_d;
  logic done_q, done_d;
  logic [MODE_W-1:0] mode_q, mode_d;

  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [WIDTH_W-1:0] wid_q, wid_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [DELAY_W-1:0] dcnt_q, dcnt_d;
  logic [WIDTH_W-1:0] wcnt_q, wcnt_d;
  logic [REP_W-1:0]   pcnt_q, pcnt_d;

  logic [DELAY_W-1:0] f_dly;
  logic [WIDTH_W-1:0] f_wid;
  logic [REP_W-1:0]   f_rep;
  logic [MODE_W-1:0]  f_mode;
  logic               go_next;

  assign {f_dly, f_wid, f_rep, f_mode} = bus.fifo_in;

`ifdef GLITCH_SEQ_TRIG_EN
  logic [2:0] trig_s_q;
  logic       trig_edge;

  // two-flop synchroniser plus one history flop for edge detect
  always_ff @(posedge clk_in) begin
    if (rst) trig_s_q <= '0;
    else     trig_s_q <= {trig_s_q[1:0], trig_in};
  end

  assign trig_edge = trig_s_q[1] & ~trig_s_q[2];
`endif

  always_comb begin
    state_d   = state_q;
    fifo_re_d = 1'b0;
    rst_req_d = 1'b0;
    done_d    = 1'b0;
    en_d      = en_q;
    mode_d    = mode_q;
    dly_d     = dly_q;
    wid_d     = wid_q;
    rep_d     = rep_q;
    dcnt_d    = dcnt_q;
    wcnt_d    = wcnt_q;
    pcnt_d    = pcnt_q;
    go_next   = 1'b0;

    if (bus.abort) begin
      state_d = IDLE;
      en_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.fifo_empty) begin
            rst_req_d = 1'b1;
            fifo_re_d = 1'b1;
            state_d   = FETCH;
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          dly_d  = f_dly;
          wid_d  = f_wid;
          rep_d  = f_rep;
          mode_d = f_mode;
          dcnt_d = '0;
          wcnt_d = '0;
          pcnt_d = '0;
          if (f_wid == '0) begin
            go_next = 1'b1;
`ifdef GLITCH_SEQ_TRIG_EN
          end else begin
            state_d = ARM;
          end
`else
          end else if (f_dly == '0) begin
            en_d    = 1'b1;
            state_d = WIDTH;
          end else begin
            state_d = DELAY;
          end
`endif
        end
`ifdef GLITCH_SEQ_TRIG_EN
        ARM: begin
          if (trig_edge) begin
            if (dly_q == '0) begin
              en_d    = 1'b1;
              state_d = WIDTH;
            end else begin
              state_d = DELAY;
            end
          end
        end
`endif
        DELAY: begin
          dcnt_d = dcnt_q + DELAY_W'(1);
          if (dcnt_q == dly_q - DELAY_W'(1)) begin
            en_d    = 1'b1;
            state_d = WIDTH;
          end
        end
        WIDTH: begin
          wcnt_d = wcnt_q + WIDTH_W'(1);
          if (wcnt_q == wid_q - WIDTH_W'(1)) begin
            en_d   = 1'b0;
            dcnt_d = '0;
            wcnt_d = '0;
            if (pcnt_q < rep_q) begin
              pcnt_d = pcnt_q + REP_W'(1);
              // zero delay: pulses run back to back as one long pulse
              if (dly_q != '0) state_d = DELAY;
              else             en_d    = 1'b1;
            end else begin
              go_next = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (go_next) begin
        if (!bus.fifo_empty) begin
          fifo_re_d = 1'b1;
          state_d   = FETCH;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      fifo_re_q <= 1'b0;
      rst_req_q <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      mode_q    <= '0;
      dly_q     <= '0;
      wid_q     <= '0;
      rep_q     <= '0;
      dcnt_q    <= '0;
      wcnt_q    <= '0;
      pcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      fifo_re_q <= fifo_re_d;
      rst_req_q <= rst_req_d;
      en_q      <= en_d;
      done_q    <= done_d;
      mode_q    <= mode_d;
      dly_q     <= dly_d;
      wid_q     <= wid_d;
      rep_q     <= rep_d;
      dcnt_q    <= dcnt_d;
      wcnt_q    <= wcnt_d;
      pcnt_q    <= pcnt_d;
    end
  end

  assign bus.fifo_re     = fifo_re_q;
  assign bus.rst_req     = rst_req_q;
  assign bus.glitch_en   = en_q;
  assign bus.glitch_mode = mode_q;
  assign bus.done        = done_q;
  assign bus.ready       = (state_q == IDLE);

endmodule

// File: tb/tb_glitch_seq.sv
// tb_glitch_seq: random command runs against a timeline model of glitch_seq.
// Build with GLITCH_SEQ_TRIG_EN defined to exercise the trigger path.
module tb_glitch_seq;
  localparam int DW    = 16;
  localparam int WW    = 8;
  localparam int RW    = 4;
  localparam int MW    = 8;
  localparam int CMD_W = DW + WW + RW + MW;
  localparam int TMAX  = 1024;

  typedef struct {
    int d;
    int w;
    int r;
    int m;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b0;

  always #5 clk = ~clk;

  glitch_seq_if #(.CMD_W(CMD_W), .MODE_W(MW)) bus ();

  glitch_seq #(
    .DELAY_W(DW), .WIDTH_W(WW),
    .REP_W(RW), .MODE_W(MW)
  ) dut (
    .clk_in(clk),
    .rst(rst),
`ifdef GLITCH_SEQ_TRIG_EN
    .trig_in(trig),
`endif
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  cmd_t fq[$];
  cmd_t mq[$];
  logic re_prev;
  int mode_cur = 0;

  int ex_en[TMAX];
  int ex_re[TMAX];
  int ex_rr[TMAX];
  int ex_dn[TMAX];
  int ex_rdy[TMAX];
  int ex_mode[TMAX];
  int tlen;
  int e_last;
  int a_cyc;
  int n_exp_pop;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] pack(cmd_t c);
    return {DW'(c.d), WW'(c.w), RW'(c.r), MW'(c.m)};
  endfunction

  // FIFO with one-cycle read latency behind the strobe
  task automatic step();
    re_prev = bus.fifo_re;
    @(posedge clk);
    #1;
    if (re_prev && fq.size() > 0)
      bus.fifo_in = pack(fq.pop_front());
    bus.fifo_empty = (fq.size() == 0);
  endtask

  task automatic push(input int d, input int w,
                      input int r, input int m);
    cmd_t c;
    c = '{d, w, r, m};
    fq.push_back(c);
    mq.push_back(c);
    bus.fifo_empty = 1'b0;
  endtask

  // Cycle 0 is the cycle right after start is sampled.
  task automatic build_model();
    cmd_t c;
    int l, e, f, s;
    for (int t = 0; t < TMAX; t++) begin
      ex_en[t] = 0; ex_re[t] = 0; ex_rr[t] = 0;
      ex_dn[t] = 0; ex_rdy[t] = 1;
      ex_mode[t] = mode_cur;
    end
    n_exp_pop = 0;
    tlen = 4;
    e_last = -1;
    if (mq.size() == 0) return;
    ex_rr[0] = 1;
    e = -1;
    for (int i = 0; i < mq.size(); i++) begin
      c = mq[i];
      f = e + 1;
      ex_re[f] = 1;
      if (a_cyc < 0 || f <= a_cyc) n_exp_pop++;
      l = e + 2;
      for (int t = l + 1; t < TMAX; t++) ex_mode[t] = c.m;
      if (c.w == 0) begin
        e = l;
      end else begin
        for (int k = 0; k <= c.r; k++) begin
          s = l + 1 + c.d + k * (c.w + c.d);
          for (int t = s; t < s + c.w; t++) ex_en[t] = 1;
        end
        e = l + (c.r + 1) * (c.d + c.w);
      end
      for (int t = f; t <= e; t++) ex_rdy[t] = 0;
    end
    ex_dn[e + 1] = 1;
    e_last = e;
    tlen = e + 4;
    if (a_cyc >= 0) begin
      for (int t = a_cyc + 1; t < TMAX; t++) begin
        ex_en[t] = 0; ex_re[t] = 0; ex_rr[t] = 0;
        ex_dn[t] = 0; ex_rdy[t] = 1;
        ex_mode[t] = ex_mode[a_cyc];
      end
      tlen = a_cyc + 4;
    end
  endtask

  // ab: -1 no abort, -2 random abort, >=0 abort in that cycle
  task automatic run(input int ab);
    int ms;
    a_cyc = -1;
    build_model();
    if (ab == -2) ab = (e_last >= 0) ? $urandom_range(e_last, 0) : -1;
    a_cyc = ab;
    build_model();
    ms = $urandom_range(tlen - 1, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int t = 0; t < tlen; t++) begin
      chk($sformatf("glitch_en@%0d", t), 32'(bus.glitch_en), ex_en[t]);
      chk($sformatf("fifo_re@%0d", t), 32'(bus.fifo_re), ex_re[t]);
      chk($sformatf("rst_req@%0d", t), 32'(bus.rst_req), ex_rr[t]);
      chk($sformatf("done@%0d", t), 32'(bus.done), ex_dn[t]);
      chk($sformatf("ready@%0d", t), 32'(bus.ready), ex_rdy[t]);
      chk($sformatf("mode@%0d", t), 32'(bus.glitch_mode), ex_mode[t]);
      bus.abort = (t == a_cyc);
      bus.start = (t == ms && ex_rdy[t] == 0);
      step();
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < n_exp_pop; i++) mq.delete(0);
    chk("fifo_left", fq.size(), mq.size());
    mode_cur = ex_mode[tlen - 1];
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.fifo_in = '0;
    bus.fifo_empty = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_ready", 32'(bus.ready), 1);
    chk("rst_en", 32'(bus.glitch_en), 0);
    chk("rst_fifo_re", 32'(bus.fifo_re), 0);
    chk("rst_rst_req", 32'(bus.rst_req), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_mode", 32'(bus.glitch_mode), 0);
    step();

`ifdef GLITCH_SEQ_TRIG_EN
    push(5, 1, 0, 8'hC3);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int t = 0; t < 34; t++) begin
      chk($sformatf("trig_en@%0d", t),
          32'(bus.glitch_en), 32'(t == 29));
      chk($sformatf("trig_done@%0d", t),
          32'(bus.done), 32'(t == 30));
      if (t == 21) trig = 1'b1;
      step();
    end
`else
    run(-1);
    push(3, 2, 0, 8'h5A);
    run(-1);
    push(0, 4, 0, 8'h33);
    push(0, 0, 0, 8'h44);
    run(-1);
    push(2, 1, 2, 8'h77);
    run(-1);
    push(1, 2, 1, 8'h01);
    push(0, 3, 0, 8'h02);
    push(2, 1, 0, 8'h03);
    run(-1);
    push(1, 10, 0, 8'h11);
    push(2, 1, 0, 8'h22);
    run(4);
    run(-1);
    push(0, 3, 15, 8'hE1);
    push(200, 255, 0, 8'hFF);
    run(-1);

    for (int n = 0; n < 40; n++) begin
      int nc;
      nc = $urandom_range(3, 0);
      for (int i = 0; i < nc; i++)
        push($urandom_range(4, 0), $urandom_range(4, 0),
             $urandom_range(3, 0), $urandom_range(255, 0));
      run(($urandom_range(2, 0) == 0) ? -2 : -1);
    end

    push(0, 8, 0, 8'h99);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    chk("pre_rst_en", 32'(bus.glitch_en), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_en", 32'(bus.glitch_en), 0);
    chk("mid_rst_ready", 32'(bus.ready), 1);
    chk("mid_rst_mode", 32'(bus.glitch_mode), 0);
    rst = 1'b0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
